twofish_dec_sequencer: RTL and testbench
========================================

# twofish_dec_sequencer

Iterative Twofish decryption engine controller. It accepts one 128-bit ciphertext block over a valid/ready handshake and runs input whitening, 16 decryption rounds (15 down to 0) and output whitening through a single shared round datapath. Subkeys come from an external subkey store with a synchronous read port. It returns the 128-bit plaintext over a second valid/ready handshake. It sits between the block-level stream interface and the precomputed key schedule.

## Interface
- No parameters; all widths are fixed by Twofish.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  ciphertext block offered.
- `in_ready`  out  1  engine idle; can accept a block.
- `in_data`  in  128  ciphertext; word0 = [31:0] … word3 = [127:96].
- `s0`, `s1`  in  32 each  S-box key words; must be stable while busy.
- `kidx`  out  5  subkey-pair index i, selecting pair (K[2i], K[2i+1]).
- `kpair`  in  64  pair read data, valid the cycle after `kidx`; K[2i] = [31:0].
- `out_valid`  out  1  plaintext block available.
- `out_ready`  in  1  consumer accepts the block.
- `out_data`  out  128  plaintext, same word order as `in_data`.
- `busy`  out  1  high from accept until the output handshake completes.

## Operation
- FSM states: IDLE, WIN0, WIN1, ROUND, WOUT0, WOUT1, DONE.
- `in_ready` = (state == IDLE). `busy` = !IDLE.
- In IDLE, `kidx` = 2.
- Accept (`in_valid && in_ready`): latch words R0..R3 and go to WIN0.
- WIN0: R0 ^= K4, R1 ^= K5; `kidx` = 3.
- WIN1: R2 ^= K6, R3 ^= K7; round counter r = 15.
- ROUND, one round per cycle using pair 4+r:
  - (F0, F1) = F(R0, R1, K[2r+8], K[2r+9], s0, s1)
  - R2' = rol1(R2) ^ F0
  - R3' = ror1(R3 ^ F1)
  - New state = (R2', R3', R0, R1)
  - r decrements; leave ROUND after r = 0.
- WOUT0 and WOUT1 first undo the final swap, so out words = (R2, R3, R0, R1). WOUT0 XORs out words 0,1 with K0, K1; WOUT1 XORs out words 2,3 with K2, K3. Then go to DONE.
- `kidx` sequence, each value driven one cycle before its use: 2, 3, 19, 18, …, 4, 0, 1.
- DONE: `out_valid` = 1 and `out_data` is stable until `out_ready`. The handshake returns the FSM to IDLE.
- Add/rotate arithmetic is mod 2^32. Rotates are 1-bit circular.
- `in_valid` outside IDLE is ignored; blocks never overlap.
- `s0`/`s1` changes while busy produce undefined output; this is not checked.

## Timing
- Accept at cycle T → WIN0 at T+1, ROUND r = 15 at T+3, r = 0 at T+18, WOUT1 at T+20, `out_valid` at T+21.
- Latency from accept to first `out_valid` is 21 cycles.
- Output handshake at cycle D → `in_ready` = 1 at D+1. Sustained throughput is one block per 22 cycles with `out_ready` held high.
- Reset, including mid-block: state → IDLE, all data registers → 0, r → 0, `out_valid` = 0, `busy` = 0. `in_ready` = 1 and `kidx` = 2 while `rst_n` is low. An in-flight block is discarded with no output.
- Back-pressure: `out_ready` low holds DONE indefinitely, and `out_data` must not change.

## Configuration
- `TWOFISH_DEC_SCRUB_EN` defined: the data registers are cleared to 0 in the cycle after the output handshake. `out_data` reads 0 whenever `out_valid` = 0.
- `TWOFISH_DEC_SCRUB_EN` undefined: the registers retain the last plaintext until the next accept.

## Structure
- Package `twofish_pkg` holds:
  - the FSM state enum;
  - constants `TF_ROUNDS` = 16, `TF_WIN_PAIR` = 2, `TF_WOUT_PAIR` = 0, `TF_RK_BASE` = 4;
  - rol1/ror1 functions.
- One sub-module, `twofish_dec_round`: the combinational single-round datapath with F-function, rotates and swap. Whitening XORs stay in the sequencer.

## Test plan
- Known answer: zero 128-bit key schedule, `in_data` = 9F589F5C F6122C32 B6BFEC2F 2AE8C35A (spec byte order) → `out_data` = 0 at T+21.
- `kidx` trace from accept: 2, 3, 19…4, 0, 1, then 2 held in IDLE; compare against expected every cycle.
- `out_ready` held low 10 cycles → `out_valid` and `out_data` stable, `in_ready` = 0, and a second `in_valid` is ignored.
- `rst_n` pulsed low at round r = 7 → all outputs at reset values immediately. A new block then decrypts correctly.
- Back-to-back: 8 random blocks with `out_ready` = 1 → each matches the golden model, 22-cycle spacing.
- With `TWOFISH_DEC_SCRUB_EN`: after handshake, `out_data` = 0 the next cycle.

Source files
------------

// File: rtl/twofish_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | twofish_pkg                                                          |
// | Shared FSM states, schedule constants and rotate helpers.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package twofish_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WIN0  = 3'd1,
    S_WIN1  = 3'd2,
    S_ROUND = 3'd3,
    S_WOUT0 = 3'd4,
    S_WOUT1 = 3'd5,
    S_DONE  = 3'd6
  } tf_state_e;

  localparam int TF_ROUNDS    = 16;
  localparam int TF_WIN_PAIR  = 2;
  localparam int TF_WOUT_PAIR = 0;
  localparam int TF_RK_BASE   = 4;

  function automatic logic [31:0] rol1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] ror1(input logic [31:0] x);
    return {x[0], x[31:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/twofish_dec_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | twofish_dec_round                                                    |
// | Combinational single Twofish decryption round (F, rotates, swap).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module twofish_dec_round
  import twofish_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [31:0]  i_k_even,
  input  logic [31:0]  i_k_odd,
  input  logic [31:0]  i_s0,
  input  logic [31:0]  i_s1,
  output logic [127:0] o_state
);

  // Nibble tables of the q0/q1 permutations, entry n at bits [4n+3:4n].
  localparam logic [63:0] c_q0_t0 = 64'h4ACE95B023F6D718;
  localparam logic [63:0] c_q0_t1 = 64'hD9076A4F53218BCE;
  localparam logic [63:0] c_q0_t2 = 64'h17423F8C09D6E5AB;
  localparam logic [63:0] c_q0_t3 = 64'hAC5803B9E6214F7D;
  localparam logic [63:0] c_q1_t0 = 64'h5CA04913E67FDB82;
  localparam logic [63:0] c_q1_t1 = 64'h809F5AD673C4B2E1;
  localparam logic [63:0] c_q1_t2 = 64'hF3B28DE0A96157C4;
  localparam logic [63:0] c_q1_t3 = 64'hA802F746ED3C159B;

  function automatic logic [7:0] q_perm(input logic sel, input logic [7:0] x);
    logic [63:0] t0, t1, t2, t3;
    logic [3:0]  a1, b1, a2, b2, a3, b3, a4, b4;
    t0 = sel ? c_q1_t0 : c_q0_t0;
    t1 = sel ? c_q1_t1 : c_q0_t1;
    t2 = sel ? c_q1_t2 : c_q0_t2;
    t3 = sel ? c_q1_t3 : c_q0_t3;
    a1 = x[7:4] ^ x[3:0];
    b1 = x[7:4] ^ {x[0], x[3:1]} ^ {x[4], 3'b000};
    a2 = t0[{a1, 2'b00} +: 4];
    b2 = t1[{b1, 2'b00} +: 4];
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    a4 = t2[{a3, 2'b00} +: 4];
    b4 = t3[{b3, 2'b00} +: 4];
    return {b4, a4};
  endfunction

  // GF(2^8) product modulo x^8+x^6+x^5+x^3+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] acc, v;
    acc = 8'h00;
    v   = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ v;
      v = v[7] ? ({v[6:0], 1'b0} ^ 8'h69) : {v[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Key-dependent S-boxes (s0 outer, s1 inner) followed by the MDS matrix.
  function automatic logic [31:0] g_fn(input logic [31:0] x, input logic [31:0] l0,
                                       input logic [31:0] l1);
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    y0 = q_perm(1'b1, q_perm(1'b0, q_perm(1'b0, x[7:0])   ^ l1[7:0])   ^ l0[7:0]);
    y1 = q_perm(1'b0, q_perm(1'b0, q_perm(1'b1, x[15:8])  ^ l1[15:8])  ^ l0[15:8]);
    y2 = q_perm(1'b1, q_perm(1'b1, q_perm(1'b0, x[23:16]) ^ l1[23:16]) ^ l0[23:16]);
    y3 = q_perm(1'b0, q_perm(1'b1, q_perm(1'b1, x[31:24]) ^ l1[31:24]) ^ l0[31:24]);
    z0 = y0 ^ gf_mul(y1, 8'hEF) ^ gf_mul(y2, 8'h5B) ^ gf_mul(y3, 8'h5B);
    z1 = gf_mul(y0, 8'h5B) ^ gf_mul(y1, 8'hEF) ^ gf_mul(y2, 8'hEF) ^ y3;
    z2 = gf_mul(y0, 8'hEF) ^ gf_mul(y1, 8'h5B) ^ y2 ^ gf_mul(y3, 8'hEF);
    z3 = gf_mul(y0, 8'hEF) ^ y1 ^ gf_mul(y2, 8'hEF) ^ gf_mul(y3, 8'h5B);
    return {z3, z2, z1, z0};
  endfunction

  logic [31:0] w_r0, w_r1, w_r2, w_r3;
  logic [31:0] w_t0, w_t1, w_f0, w_f1, w_n2, w_n3;

  assign {w_r3, w_r2, w_r1, w_r0} = i_state;

  assign w_t0 = g_fn(w_r0, i_s0, i_s1);
  assign w_t1 = g_fn({w_r1[23:0], w_r1[31:24]}, i_s0, i_s1);
  assign w_f0 = w_t0 + w_t1 + i_k_even;
  assign w_f1 = w_t0 + {w_t1[30:0], 1'b0} + i_k_odd;

  assign w_n2 = rol1(w_r2) ^ w_f0;
  assign w_n3 = ror1(w_r3 ^ w_f1);

  assign o_state = {w_r1, w_r0, w_n3, w_n2};

endmodule
`default_nettype wire

// File: rtl/twofish_dec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | twofish_dec_sequencer                                                |
// | Iterative Twofish block decryptor: whitening, 16 rounds, whitening.  |
// | Option: TWOFISH_DEC_SCRUB_EN clears the data registers after output. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module twofish_dec_sequencer
  import twofish_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [31:0]  s0,
  input  logic [31:0]  s1,
  output logic [4:0]   kidx,
  input  logic [63:0]  kpair,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  tf_state_e    r_state, w_state_nxt;
  logic [31:0]  r_w0, r_w1, r_w2, r_w3;
  logic [3:0]   r_round;
  logic [127:0] w_round_out;

  twofish_dec_round u_round (
    .i_state  ({r_w3, r_w2, r_w1, r_w0}),
    .i_k_even (kpair[31:0]),
    .i_k_odd  (kpair[63:32]),
    .i_s0     (s0),
    .i_s1     (s1),
    .o_state  (w_round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // kidx always addresses the pair consumed in the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    kidx        = 5'(TF_WIN_PAIR);
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = S_WIN0;
      end
      S_WIN0: begin
        kidx        = 5'(TF_WIN_PAIR + 1);
        w_state_nxt = S_WIN1;
      end
      S_WIN1: begin
        kidx        = 5'(TF_RK_BASE + TF_ROUNDS - 1);
        w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        if (r_round == 4'd0) begin
          kidx        = 5'(TF_WOUT_PAIR);
          w_state_nxt = S_WOUT0;
        end else begin
          kidx = 5'(TF_RK_BASE - 1) + {1'b0, r_round};
        end
      end
      S_WOUT0: begin
        kidx        = 5'(TF_WOUT_PAIR + 1);
        w_state_nxt = S_WOUT1;
      end
      S_WOUT1: w_state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w0    <= '0;
      r_w1    <= '0;
      r_w2    <= '0;
      r_w3    <= '0;
      r_round <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) {r_w3, r_w2, r_w1, r_w0} <= in_data;
        end
        S_WIN0: begin
          r_w0 <= r_w0 ^ kpair[31:0];
          r_w1 <= r_w1 ^ kpair[63:32];
        end
        S_WIN1: begin
          r_w2    <= r_w2 ^ kpair[31:0];
          r_w3    <= r_w3 ^ kpair[63:32];
          r_round <= 4'(TF_ROUNDS - 1);
        end
        S_ROUND: begin
          {r_w3, r_w2, r_w1, r_w0} <= w_round_out;
          if (r_round != 4'd0) r_round <= r_round - 4'd1;
        end
        S_WOUT0: begin
          // Undo the swap of the last round while whitening words 0 and 1.
          r_w0 <= r_w2 ^ kpair[31:0];
          r_w1 <= r_w3 ^ kpair[63:32];
          r_w2 <= r_w0;
          r_w3 <= r_w1;
        end
        S_WOUT1: begin
          r_w2 <= r_w2 ^ kpair[31:0];
          r_w3 <= r_w3 ^ kpair[63:32];
        end
        S_DONE: begin
`ifdef TWOFISH_DEC_SCRUB_EN
          if (out_ready) begin
            r_w0 <= '0;
            r_w1 <= '0;
            r_w2 <= '0;
            r_w3 <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef TWOFISH_DEC_SCRUB_EN
  assign out_data = out_valid ? {r_w3, r_w2, r_w1, r_w0} : 128'd0;
`else
  assign out_data = {r_w3, r_w2, r_w1, r_w0};
`endif

endmodule
`default_nettype wire

// File: tb/tb_twofish_dec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_twofish_dec_sequencer                                             |
// | Scoreboard bench with a block-level Twofish decryption model.        |
// | Honours TWOFISH_DEC_SCRUB_EN for the post-handshake output check.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_twofish_dec_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [31:0]  sk0 = '0, sk1 = '0;
  logic [4:0]   kidx;
  logic [63:0]  kpair = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  twofish_dec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .s0(sk0), .s1(sk1), .kidx(kidx), .kpair(kpair),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Subkey store with a one-cycle synchronous read.
  logic [31:0] kmem [40];
  always @(posedge clk)
    kpair <= (kidx < 5'd20) ? {kmem[2*kidx+1], kmem[2*kidx]} : 64'h0;

  logic [127:0] exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h expected no block", out_data);
      end else begin
        check("plaintext", out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  int qt [2][4][16] = '{
    '{'{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4},
      '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
      '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1},
      '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10}},
    '{'{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5},
      '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
      '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15},
      '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10}}};
  int qtab [2][256];
  int q_in  [4] = '{0, 1, 0, 1};
  int q_mid [4] = '{0, 0, 1, 1};
  int q_out [4] = '{1, 0, 1, 0};
  int mds [4][4] = '{'{'h01,'hEF,'h5B,'h5B}, '{'h5B,'hEF,'hEF,'h01},
                     '{'hEF,'h5B,'h01,'hEF}, '{'hEF,'h01,'hEF,'h5B}};

  function automatic int ror4(int b);
    return ((b >> 1) | (b << 3)) & 15;
  endfunction

  function automatic int qcalc(int w, int x);
    int a0, b0, a1, b1, a2, b2, a3, b3;
    a0 = x >> 4;  b0 = x & 15;
    a1 = a0 ^ b0; b1 = a0 ^ ror4(b0) ^ ((a0 << 3) & 15);
    a2 = qt[w][0][a1]; b2 = qt[w][1][b1];
    a3 = a2 ^ b2; b3 = a2 ^ ror4(b2) ^ ((a2 << 3) & 15);
    return qt[w][3][b3] * 16 + qt[w][2][a3];
  endfunction

  function automatic int gmul(int a, int b);
    int p = 0;
    while (b != 0) begin
      if ((b & 1) != 0) p ^= a;
      a = a << 1;
      if ((a & 'h100) != 0) a ^= 'h169;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] rotl(logic [31:0] x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] h_fn(logic [31:0] x, logic [31:0] l0, logic [31:0] l1);
    int y [4];
    int zi;
    logic [31:0] z = '0;
    for (int j = 0; j < 4; j++) begin
      y[j] = qtab[q_in[j]][x[8*j +: 8]];
      y[j] = qtab[q_mid[j]][y[j] ^ int'(l1[8*j +: 8])];
      y[j] = qtab[q_out[j]][y[j] ^ int'(l0[8*j +: 8])];
    end
    for (int i = 0; i < 4; i++) begin
      zi = 0;
      for (int j = 0; j < 4; j++) zi ^= gmul(mds[i][j], y[j]);
      z[8*i +: 8] = zi[7:0];
    end
    return z;
  endfunction

  function automatic logic [127:0] model_dec(logic [127:0] ct);
    logic [31:0] x [4];
    logic [31:0] t0, t1, f0, f1, n2, n3;
    for (int j = 0; j < 4; j++) x[j] = ct[32*j +: 32] ^ kmem[4+j];
    for (int r = 15; r >= 0; r--) begin
      t0 = h_fn(x[0], sk0, sk1);
      t1 = h_fn(rotl(x[1], 8), sk0, sk1);
      f0 = t0 + t1 + kmem[2*r+8];
      f1 = t0 + 2 * t1 + kmem[2*r+9];
      n2 = rotl(x[2], 1) ^ f0;
      n3 = rotl(x[3] ^ f1, 31);
      x[3] = x[1]; x[2] = x[0]; x[1] = n3; x[0] = n2;
    end
    return {x[1] ^ kmem[3], x[0] ^ kmem[2], x[3] ^ kmem[1], x[2] ^ kmem[0]};
  endfunction

  // Standard schedule for the all-zero 128-bit key (S-box words are zero too).
  task automatic load_zero_key();
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = h_fn({4{8'(2*i)}}, 32'h0, 32'h0);
      b = rotl(h_fn({4{8'(2*i+1)}}, 32'h0, 32'h0), 8);
      kmem[2*i]   = a + b;
      kmem[2*i+1] = rotl(a + 2 * b, 9);
    end
    sk0 = '0;
    sk1 = '0;
  endtask

  task automatic rand_keys();
    for (int i = 0; i < 40; i++) kmem[i] = $urandom;
    sk0 = $urandom;
    sk1 = $urandom;
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] d, input bit push, output int acc);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
    end
    in_data  = d;
    in_valid = 1'b1;
    acc      = cyc;
    if (push) exp_q.push_back(model_dec(d));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  128'(in_ready),  128'd1);
    check({tag, "_busy"},      128'(busy),      128'd0);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_kidx"},      128'(kidx),      128'd2);
    check({tag, "_out_data"},  out_data,        128'd0);
  endtask

  initial begin
    int acc, prev, n;
    int ek [$];
    logic [127:0] d, e;

    for (int w = 0; w < 2; w++)
      for (int x = 0; x < 256; x++) qtab[w][x] = qcalc(w, x);
    for (int i = 0; i < 40; i++) kmem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Known answer plus kidx / latency trace
    load_zero_key();
    ek = {2, 3};
    for (int v = 19; v >= 4; v--) ek.push_back(v);
    ek.push_back(0);
    ek.push_back(1);
    exp_q.push_back(128'd0);
    send({32'h5AC3E82A, 32'h2FECBFB6, 32'h322C12F6, 32'h5C9F589F}, 1'b0, acc);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      check($sformatf("kidx_t%0d", i), 128'(kidx), 128'((i < 20) ? ek[i] : 2));
      check($sformatf("out_valid_t%0d", i), 128'(out_valid), 128'(i == 21));
      check($sformatf("busy_t%0d", i), 128'(busy), 128'(i <= 21));
    end
    check("kat_in_ready_after", 128'(in_ready), 128'd1);

    // Back-pressure: output held, second block ignored
    rand_keys();
    @(posedge clk);
    #1 out_ready = 1'b0;
    d = rand_blk();
    e = model_dec(d);
    exp_q.push_back(e);
    send(d, 1'b0, acc);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("bp_out_valid", 128'(out_valid), 128'd1);
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_valid", 128'(out_valid), 128'd1);
      check("bp_hold_data", out_data, e);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      in_valid = 1'b1;
      in_data  = rand_blk();
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after", 128'(in_ready), 128'd1);
`ifdef TWOFISH_DEC_SCRUB_EN
    check("scrub_out_data", out_data, 128'd0);
`else
    check("retain_out_data", out_data, e);
`endif
    repeat (30) @(negedge clk);
    check("bp_no_extra_block", 128'(exp_q.size()), 128'd0);

    // Reset in the middle of round 7
    rand_keys();
    send(rand_blk(), 1'b0, acc);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    send(rand_blk(), 1'b1, acc);
    drain();

    // Back-to-back random blocks
    rand_keys();
    prev = 0;
    for (int b = 0; b < 8; b++) begin
      send(rand_blk(), 1'b1, acc);
      if (b > 0) check("b2b_spacing", 128'(acc - prev), 128'd22);
      prev = acc;
    end
    drain();
    repeat (5) @(negedge clk);
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
